// File: rtl/vm_multi_if.sv
// Vending machine bus: customer and dispenser inputs plus vend/status outputs.
// The master drives coins and requests, and the slave (vm_multi) drives the results.
interface vm_multi_if #(
  parameter int unsigned N_ITEM   = 4,
  parameter int unsigned CREDIT_W = 8
);
  logic [1:0]          Coin;
  logic [N_ITEM-1:0]   Select;
  logic                Refund;
  logic                ChangeAck;
  logic [N_ITEM-1:0]   Drink;
  logic                Reject;
  logic                Short;
  logic                ChangeReq;
  logic [CREDIT_W-1:0] Credit;

  modport master (
    output Coin, Select, Refund, ChangeAck,
    input  Drink, Reject, Short, ChangeReq, Credit
  );

  modport slave (
    input  Coin, Select, Refund, ChangeAck,
    output Drink, Reject, Short, ChangeReq, Credit
  );
endinterface

// File: rtl/vm_multi.sv
// Multi-product vending controller: coin credit, one-hot select, vend and coin-by-coin change.
// Define VM_AUTO_CHANGE_EN to return leftover credit automatically after each vend.
module vm_multi #(
  parameter int unsigned N_ITEM     = 4,
  parameter int unsigned CREDIT_W   = 8,
  parameter int unsigned MAX_CREDIT = 40,
  parameter logic [N_ITEM*CREDIT_W-1:0] PRICE_VEC = {8'd12, 8'd10, 8'd6, 8'd4}
) (
  input  logic       CLK,
  input  logic       nRESET,
  vm_multi_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CREDIT, VEND, CHANGE} state_t;

  state_t              state_q;
  logic [CREDIT_W-1:0] credit_q;
  logic [N_ITEM-1:0]   drink_q;
  logic                reject_q;
  logic                short_q;
  logic                change_req_q;

  logic                coin_valid;
  logic [CREDIT_W-1:0] coin_units;
  logic [CREDIT_W-1:0] credit_add_d;
  logic                coin_fits;
  logic                sel_onehot;
  logic [CREDIT_W-1:0] sel_price;
  logic                sel_afford;
  logic [CREDIT_W-1:0] credit_vend_d;

  always_comb begin
    coin_valid = (bus.Coin != 2'b00);
    unique case (bus.Coin)
      2'b01:   coin_units = CREDIT_W'(1);
      2'b10:   coin_units = CREDIT_W'(2);
      2'b11:   coin_units = CREDIT_W'(10);
      default: coin_units = '0;
    endcase
    // MAX_CREDIT + 10 fits in CREDIT_W, so this sum cannot wrap
    credit_add_d = credit_q + coin_units;
    coin_fits    = (credit_add_d <= CREDIT_W'(MAX_CREDIT));

    sel_onehot = $onehot(bus.Select);
    sel_price  = '0;
    for (int unsigned i = 0; i < N_ITEM; i++) begin
      if (bus.Select[i]) sel_price = PRICE_VEC[i*CREDIT_W +: CREDIT_W];
    end
    sel_afford    = (credit_q >= sel_price);
    credit_vend_d = credit_q - sel_price;
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q      <= IDLE;
      credit_q     <= '0;
      drink_q      <= '0;
      reject_q     <= 1'b0;
      short_q      <= 1'b0;
      change_req_q <= 1'b0;
    end else begin
      drink_q  <= '0;
      reject_q <= 1'b0;
      short_q  <= 1'b0;
      case (state_q)
        IDLE, CREDIT: begin
          // Coins outrank Refund, which outranks Select
          if (coin_valid) begin
            if (coin_fits) begin
              credit_q <= credit_add_d;
              state_q  <= CREDIT;
            end else begin
              reject_q <= 1'b1;
            end
          end else if (state_q == CREDIT) begin
            if (bus.Refund) begin
              state_q      <= CHANGE;
              change_req_q <= 1'b1;
            end else if (sel_onehot) begin
              if (sel_afford) begin
                state_q  <= VEND;
                drink_q  <= bus.Select;
                credit_q <= credit_vend_d;
              end else begin
                short_q <= 1'b1;
              end
            end
          end
        end
        VEND: begin
          if (coin_valid) reject_q <= 1'b1;
          if (credit_q == '0) begin
            state_q <= IDLE;
          end else begin
`ifdef VM_AUTO_CHANGE_EN
            state_q      <= CHANGE;
            change_req_q <= 1'b1;
`else
            state_q <= CREDIT;
`endif
          end
        end
        CHANGE: begin
          if (coin_valid) reject_q <= 1'b1;
          if (change_req_q && bus.ChangeAck) begin
            credit_q <= credit_q - CREDIT_W'(1);
            if (credit_q == CREDIT_W'(1)) begin
              change_req_q <= 1'b0;
              state_q      <= IDLE;
            end
          end
        end
      endcase
    end
  end

  assign bus.Drink     = drink_q;
  assign bus.Reject    = reject_q;
  assign bus.Short     = short_q;
  assign bus.ChangeReq = change_req_q;
  assign bus.Credit    = credit_q;

endmodule

// File: tb/tb_vm_multi.sv
// Self-checking bench for vm_multi: directed scenarios followed by random stimulus,
// each cycle compared against a transaction-level model of the vending rules.
module tb_vm_multi;

  localparam int MAX = 40;

  logic CLK;
  logic nRESET;

  vm_multi_if #(.N_ITEM(4), .CREDIT_W(8)) bus ();

  vm_multi #(
    .N_ITEM(4),
    .CREDIT_W(8),
    .MAX_CREDIT(40),
    .PRICE_VEC({8'd12, 8'd10, 8'd6, 8'd4})
  ) dut (
    .CLK(CLK),
    .nRESET(nRESET),
    .bus(bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Model state: banked credit, whether a vend cycle is in progress, whether change is being paid out
  int   price [4] = '{4, 6, 10, 12};
  int   m_credit;
  bit   m_vend;
  bit   m_change;
  logic [3:0] e_drink;
  bit   e_reject;
  bit   e_short;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_credit = 0;
    m_vend   = 0;
    m_change = 0;
    e_drink  = '0;
    e_reject = 0;
    e_short  = 0;
  endtask

  task automatic model_edge(input logic [1:0] c, input logic [3:0] s, input logic r, input logic a);
    int u;
    u = (c == 2'd1) ? 1 : (c == 2'd2) ? 2 : (c == 2'd3) ? 10 : 0;
    e_drink  = '0;
    e_reject = 0;
    e_short  = 0;
    if (m_vend) begin
      if (u != 0) e_reject = 1;
      m_vend = 0;
`ifdef VM_AUTO_CHANGE_EN
      if (m_credit > 0) m_change = 1;
`endif
    end else if (m_change) begin
      if (u != 0) e_reject = 1;
      if (a) begin
        m_credit--;
        if (m_credit == 0) m_change = 0;
      end
    end else if (u != 0) begin
      if (m_credit + u <= MAX) m_credit += u;
      else e_reject = 1;
    end else if (m_credit > 0) begin
      if (r) m_change = 1;
      else if ($countones(s) == 1) begin
        int idx = 0;
        for (int k = 0; k < 4; k++) if (s[k]) idx = k;
        if (m_credit >= price[idx]) begin
          m_credit -= price[idx];
          e_drink = s;
          m_vend = 1;
        end else begin
          e_short = 1;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".Drink"},     32'(bus.Drink),     32'(e_drink));
    chk({tag, ".Reject"},    32'(bus.Reject),    32'(e_reject));
    chk({tag, ".Short"},     32'(bus.Short),     32'(e_short));
    chk({tag, ".ChangeReq"}, 32'(bus.ChangeReq), 32'(m_change));
    chk({tag, ".Credit"},    32'(bus.Credit),    32'(m_credit));
  endtask

  task automatic step(input string tag, input logic [1:0] c, input logic [3:0] s,
                      input logic r, input logic a);
    @(negedge CLK);
    bus.Coin      = c;
    bus.Select    = s;
    bus.Refund    = r;
    bus.ChangeAck = a;
    @(posedge CLK);
    model_edge(c, s, r, a);
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int k = 0; k < n; k++) step(tag, 2'b00, 4'b0000, 1'b0, 1'b0);
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 60 && m_change; k++) step(tag, 2'b00, 4'b0000, 1'b0, 1'b1);
    chk({tag, ".drained"}, 32'(m_change), 32'd0);
  endtask

  // Asserts nRESET between clock edges and checks the outputs clear without waiting for a clock
  task automatic async_reset(input string tag);
    @(posedge CLK);
    #3 nRESET = 1'b0;
    model_reset();
    #1;
    check_all(tag);
    @(negedge CLK);
    nRESET = 1'b1;
  endtask

  initial begin
    bus.Coin = 2'b00; bus.Select = '0; bus.Refund = 1'b0; bus.ChangeAck = 1'b0;
    nRESET = 1'b0;
    model_reset();
    repeat (3) @(posedge CLK);
    #1 check_all("reset");
    @(negedge CLK) nRESET = 1'b1;

    // 100+100, buy item 0 (price 4); coin during the vend cycle is rejected
    step("s1_c100a", 2'b10, 4'b0000, 0, 0);
    step("s1_c100b", 2'b10, 4'b0000, 0, 0);
    step("s1_sel0",  2'b00, 4'b0001, 0, 0);
    step("s1_vendc", 2'b01, 4'b0000, 0, 0);
    idle("s1_idle", 2);

    // 500, buy item 2 (price 10) for exact credit
    step("s2_c500", 2'b11, 4'b0000, 0, 0);
    step("s2_sel2", 2'b00, 4'b0100, 0, 0);
    idle("s2_idle", 2);

    // 500, item 3 too expensive, refund with stalled acks
    step("s3_c500",  2'b11, 4'b0000, 0, 0);
    step("s3_sel3",  2'b00, 4'b1000, 0, 0);
    step("s3_ref",   2'b00, 4'b0000, 1, 0);
    for (int k = 0; k < 3; k++) step("s3_stall", 2'b00, 4'b0000, 0, 0);
    step("s3_selchg", 2'b00, 4'b0001, 1, 1);
    drain("s3_drain");
    idle("s3_idle", 1);

    // fill to ceiling, overflow reject, coin during change
    for (int k = 0; k < 4; k++) step("s4_c500", 2'b11, 4'b0000, 0, 0);
    step("s4_over", 2'b01, 4'b0000, 0, 0);
    step("s4_ref",  2'b00, 4'b0000, 1, 0);
    step("s4_chgc", 2'b10, 4'b0000, 0, 1);
    drain("s4_drain");

    // coin beats select; non-one-hot select ignored; coin beats refund
    step("s5_cosel", 2'b10, 4'b0001, 0, 0);
    step("s5_multi", 2'b00, 4'b0011, 0, 0);
    step("s5_coref", 2'b01, 4'b0000, 1, 0);
    step("s5_ref",   2'b00, 4'b0000, 1, 0);
    drain("s5_drain");

    // multi-buy (or auto change), then reset during a payout
    step("s6_c500", 2'b11, 4'b0000, 0, 0);
    step("s6_sel0", 2'b00, 4'b0001, 0, 0);
    idle("s6_post", 1);
    step("s6_sel1", 2'b00, 4'b0010, 0, 0);
    drain("s6_drain");
    idle("s6_idle", 1);
    step("s6_c500b", 2'b11, 4'b0000, 0, 0);
    step("s6_ref",   2'b00, 4'b0000, 1, 0);
    step("s6_ack",   2'b00, 4'b0000, 0, 1);
    step("s6_ack",   2'b00, 4'b0000, 0, 1);
    async_reset("s6_rst");
    idle("s6_after", 2);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      logic [1:0] c;
      logic [3:0] s;
      logic r, a;
      c = ($urandom_range(0, 99) < 30) ? 2'($urandom_range(1, 3)) : 2'b00;
      s = ($urandom_range(0, 3) != 0) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) s = '0;
      r = ($urandom_range(0, 9) == 0);
      a = $urandom_range(0, 1) != 0;
      step("rand", c, s, r, a);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
